// File: rtl/parity_frame_rx.sv
// parity_frame_rx
// Serial frame receiver: {start, DATA_W data bits MSB first, parity, stop}.
// Checks parity and stop bit, then hands each good word to a one-entry
// valid/ready output buffer. Error and overrun flags are one-cycle pulses.
// All outputs are registered; no input reaches an output combinationally.

module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int   CNT_W   = $clog2(DATA_W) + 1;
  localparam logic PAR_INV = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Registered state
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                par_ok_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                parity_err_q;
  logic                frame_err_q;
  logic                overrun_q;

  // Next-state values
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   shreg_d;
  logic                par_ok_d;
  logic [DATA_W-1:0]   out_data_d;
  logic                out_valid_d;
  logic                parity_err_d;
  logic                frame_err_d;
  logic                overrun_d;

  logic                good_frame;
  logic                pop;

  // Consumer handshake; out_ready has no effect while the buffer is empty.
  assign pop = out_valid_q & out_ready;

  // State register and all datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      par_ok_q     <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values before this edge, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      par_ok_q     <= par_ok_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Frame FSM, parity/stop checking and output-buffer update.
  always_comb begin
    // NOTE: every signal gets a default up front; a path that skips an
    // assignment would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    par_ok_d     = par_ok_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    good_frame   = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          // A 0 on an idle line is the start bit.
          if (!rx_bit) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end

        DATA: begin
          shreg_d = {shreg_q[DATA_W-2:0], rx_bit};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end

        PARITY: begin
          // Parity is judged here so the stop cycle only has to pick an outcome.
          par_ok_d = ~((^shreg_q) ^ rx_bit ^ PAR_INV);
          state_d  = STOP;
        end

        STOP: begin
          state_d = IDLE;
          if (!rx_bit) begin
            // A bad stop bit takes precedence over a parity mismatch.
            frame_err_d = 1'b1;
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
          end else begin
            good_frame = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // A word popped in the same cycle frees the slot for the new one.
    if (good_frame) begin
      if (!out_valid_q || pop) begin
        out_data_d  = shreg_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed testbench for parity_frame_rx. Two instances share the stimulus:
// one with even parity, one with odd parity. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.

module tb_parity_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       rx_bit;
  logic       out_ready;

  logic [7:0] ev_data;
  logic       ev_valid, ev_perr, ev_ferr, ev_ovr;
  logic [7:0] od_data;
  logic       od_valid, od_perr, od_ferr, od_ovr;

  int total = 0;
  int bad   = 0;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .out_data   (ev_data),
    .out_valid  (ev_valid),
    .out_ready  (out_ready),
    .parity_err (ev_perr),
    .frame_err  (ev_ferr),
    .overrun    (ev_ovr)
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .out_data   (od_data),
    .out_valid  (od_valid),
    .out_ready  (out_ready),
    .parity_err (od_perr),
    .frame_err  (od_ferr),
    .overrun    (od_ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One strobe; returns 1 ns after the sampling edge with bit_en still high.
  task automatic strobe(input logic b);
    bit_en = 1'b1;
    rx_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    rx_bit = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, data MSB first, parity bit.
  task automatic send_head(input logic [7:0] d, input logic p);
    strobe(1'b0);
    for (int i = 7; i >= 0; i--) strobe(d[i]);
    strobe(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_head(d, p);
    strobe(s);
  endtask

  task automatic test_reset;
    rst = 1'b0; bit_en = 1'b0; rx_bit = 1'b1; out_ready = 1'b0;
    #2 rst = 1'b1;
    #5;
    total++;
    if ({ev_valid, ev_perr, ev_ferr, ev_ovr} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {ev_valid, ev_perr, ev_ferr, ev_ovr});
    end
    total++;
    if (ev_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %h want 00", ev_data);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'hA5) begin
      bad++; $display("FAIL good_word: got v=%b d=%h want v=1 d=a5", ev_valid, ev_data);
    end
    total++;
    if ({ev_perr, ev_ferr, ev_ovr} !== 3'b000) begin
      bad++; $display("FAIL good_pulses: got %b want 000", {ev_perr, ev_ferr, ev_ovr});
    end
    // The buffered word holds while the consumer is not ready.
    idle(3);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'hA5) begin
      bad++; $display("FAIL good_hold: got v=%b d=%h want v=1 d=a5", ev_valid, ev_data);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    total++;
    if (ev_valid !== 1'b0 || ev_data !== 8'hA5) begin
      bad++; $display("FAIL good_pop: got v=%b d=%h want v=0 d=a5", ev_valid, ev_data);
    end
  endtask

  task automatic test_parity_err;
    send_frame(8'hA5, 1'b1, 1'b1);
    total++;
    if ({ev_perr, ev_ferr, ev_ovr, ev_valid} !== 4'b1000) begin
      bad++; $display("FAIL perr_pulse: got perr/ferr/ovr/valid=%b want 1000", {ev_perr, ev_ferr, ev_ovr, ev_valid});
    end
    idle(1);
    total++;
    if ({ev_perr, ev_valid} !== 2'b00) begin
      bad++; $display("FAIL perr_one_cycle: got perr/valid=%b want 00", {ev_perr, ev_valid});
    end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0);
    total++;
    if ({ev_perr, ev_ferr, ev_ovr, ev_valid} !== 4'b0100) begin
      bad++; $display("FAIL ferr_pulse: got perr/ferr/ovr/valid=%b want 0100", {ev_perr, ev_ferr, ev_ovr, ev_valid});
    end
    idle(1);
    total++;
    if (ev_ferr !== 1'b0) begin
      bad++; $display("FAIL ferr_one_cycle: got %b want 0", ev_ferr);
    end
    // Bad parity and bad stop together: only the framing error is reported.
    send_frame(8'h3C, 1'b1, 1'b0);
    total++;
    if ({ev_perr, ev_ferr} !== 2'b01) begin
      bad++; $display("FAIL both_err: got perr/ferr=%b want 01", {ev_perr, ev_ferr});
    end
    idle(1);
    send_frame(8'h3C, 1'b0, 1'b1);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h3C) begin
      bad++; $display("FAIL ferr_recover: got v=%b d=%h want v=1 d=3c", ev_valid, ev_data);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h01) begin
      bad++; $display("FAIL ovr_first: got v=%b d=%h want v=1 d=01", ev_valid, ev_data);
    end
    idle(1);
    send_frame(8'h02, 1'b1, 1'b1);
    total++;
    if ({ev_ovr, ev_perr, ev_ferr} !== 3'b100 || ev_data !== 8'h01 || ev_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_pulse: got ovr/perr/ferr=%b d=%h v=%b want 100 d=01 v=1", {ev_ovr, ev_perr, ev_ferr}, ev_data, ev_valid);
    end
    idle(1);
    total++;
    if (ev_ovr !== 1'b0) begin
      bad++; $display("FAIL ovr_one_cycle: got %b want 0", ev_ovr);
    end
    // Pop and refill on the same edge as the stop bit.
    send_head(8'h03, 1'b0);
    out_ready = 1'b1;
    strobe(1'b1);
    out_ready = 1'b0;
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h03 || ev_ovr !== 1'b0) begin
      bad++; $display("FAIL pop_refill: got v=%b d=%h ovr=%b want v=1 d=03 ovr=0", ev_valid, ev_data, ev_ovr);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  // Gaps with bit_en=0 inside a frame must not disturb reception.
  task automatic test_bit_en_gaps;
    logic [7:0] d;
    d = 8'h5A;
    strobe(1'b0);
    idle(2);
    for (int i = 7; i >= 0; i--) begin
      strobe(d[i]);
      idle(i % 3);
    end
    strobe(1'b0);
    idle(4);
    total++;
    if ({ev_valid, ev_perr, ev_ferr} !== 3'b000) begin
      bad++; $display("FAIL gap_early: got v/perr/ferr=%b want 000", {ev_valid, ev_perr, ev_ferr});
    end
    strobe(1'b1);
    bit_en = 1'b0;
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h5A) begin
      bad++; $display("FAIL gap_word: got v=%b d=%h want v=1 d=5a", ev_valid, ev_data);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    total++;
    if (ev_valid !== 1'b1) begin
      bad++; $display("FAIL rst_prefill: got v=%b want 1", ev_valid);
    end
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    bit_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if ({ev_valid, ev_perr, ev_ferr, ev_ovr} !== 4'b0000 || ev_data !== 8'h00) begin
      bad++; $display("FAIL rst_async: got flags=%b d=%h want 0000 d=00", {ev_valid, ev_perr, ev_ferr, ev_ovr}, ev_data);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    send_frame(8'hFF, 1'b0, 1'b1);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'hFF || {ev_perr, ev_ferr} !== 2'b00) begin
      bad++; $display("FAIL rst_after: got v=%b d=%h err=%b want v=1 d=ff err=00", ev_valid, ev_data, {ev_perr, ev_ferr});
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  // bit_en high every cycle, ten frames, some idle 1s between them.
  task automatic test_back_to_back(input logic odd);
    logic [7:0] d;
    logic       p;
    out_ready = 1'b1;
    idle(2);
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom_range(0, 255));
      p = odd ? ~(^d) : (^d);
      send_frame(d, p, 1'b1);
      if (odd) begin
        total++;
        if (od_valid !== 1'b1 || od_data !== d || {od_perr, od_ferr, od_ovr} !== 3'b000) begin
          bad++; $display("FAIL b2b_odd[%0d]: got v=%b d=%h err=%b want v=1 d=%h err=000", k, od_valid, od_data, {od_perr, od_ferr, od_ovr}, d);
        end
        total++;
        if (ev_perr !== 1'b1) begin
          bad++; $display("FAIL b2b_odd_cross[%0d]: even perr got %b want 1", k, ev_perr);
        end
      end else begin
        total++;
        if (ev_valid !== 1'b1 || ev_data !== d || {ev_perr, ev_ferr, ev_ovr} !== 3'b000) begin
          bad++; $display("FAIL b2b_even[%0d]: got v=%b d=%h err=%b want v=1 d=%h err=000", k, ev_valid, ev_data, {ev_perr, ev_ferr, ev_ovr}, d);
        end
        total++;
        if (od_perr !== 1'b1) begin
          bad++; $display("FAIL b2b_even_cross[%0d]: odd perr got %b want 1", k, od_perr);
        end
      end
      for (int j = 0; j < (k % 3); j++) strobe(1'b1);
    end
    idle(2);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_bit_en_gaps();
    test_async_reset();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
